// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the mem-stage exception controller:
// exception codes, CP0 register addresses, Status/Cause bit positions,
// FSM state type and the interrupt / priority helper functions.
package except_ctrl_pkg;

    // Exception codes delivered to CP0
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_OVF  = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // CP0 register addresses
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Status / Cause field positions
    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_SW_LO  = 8;   // software-writable IP bits
    localparam int unsigned CAUSE_SW_HI  = 9;

    // Bit positions inside mem_excepts_i
    localparam int unsigned FLAG_SYS  = 0;
    localparam int unsigned FLAG_INV  = 1;
    localparam int unsigned FLAG_TRAP = 2;
    localparam int unsigned FLAG_OVF  = 3;
    localparam int unsigned FLAG_ERET = 4;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_e;

    // Unmasked interrupt with interrupts enabled and not already at exception level
    function automatic logic irq_pending(input logic [31:0] status, input logic [31:0] cause);
        return ((cause[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]) != '0)
               && status[STATUS_IE] && !status[STATUS_EXL];
    endfunction

    // Single winning code; interrupts outrank every synchronous exception
    function automatic logic [31:0] pick_code(input logic irq, input logic [4:0] flags);
        if (irq)                  return EXC_INT;
        else if (flags[FLAG_SYS])  return EXC_SYS;
        else if (flags[FLAG_INV])  return EXC_INV;
        else if (flags[FLAG_TRAP]) return EXC_TRAP;
        else if (flags[FLAG_OVF])  return EXC_OVF;
        else if (flags[FLAG_ERET]) return EXC_ERET;
        else                       return EXC_NONE;
    endfunction

endpackage

// File: rtl/except_ctrl_cp0_fwd.sv
// cp0_fwd: combinational forwarding of a wb-stage CP0 write onto the
// Status, Cause and EPC values seen by the mem-stage exception logic.
// Only the software-writable IP bits of Cause are taken from the wb write.
module cp0_fwd
    import except_ctrl_pkg::*;
(
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    // Newest value of each register: an in-flight wb write overrides the CP0 copy
    always_comb begin
        status_o = cp0_status_i;
        cause_o  = cp0_cause_i;
        epc_o    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                CP0_REG_STATUS: status_o = wb_cp0_wdata_i;
                CP0_REG_CAUSE:  cause_o[CAUSE_SW_HI:CAUSE_SW_LO] = wb_cp0_wdata_i[CAUSE_SW_HI:CAUSE_SW_LO];
                CP0_REG_EPC:    epc_o = wb_cp0_wdata_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: mem-stage exception arbiter.
// Merges raw exception flags with pending interrupts, reports the winning
// code to CP0 in the detection cycle, then holds a registered flush and
// redirect PC (vector, or EPC for eret) for FLUSH_CYCLES cycles.
// Optional: define EXCEPT_STATS_EN to build the taken-exception counter
// on exc_count_o; otherwise exc_count_o is tied to zero.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        stall_i,
    input  logic [4:0]  mem_excepts_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] except_type_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] exc_count_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [31:0] status_f;
    logic [31:0] cause_f;
    logic [31:0] epc_f;

    cp0_fwd u_cp0_fwd (
        .cp0_status_i   (cp0_status_i),
        .cp0_cause_i    (cp0_cause_i),
        .cp0_epc_i      (cp0_epc_i),
        .wb_cp0_we_i    (wb_cp0_we_i),
        .wb_cp0_waddr_i (wb_cp0_waddr_i),
        .wb_cp0_wdata_i (wb_cp0_wdata_i),
        .status_o       (status_f),
        .cause_o        (cause_f),
        .epc_o          (epc_f)
    );

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        take;
    logic [31:0] code;

    // Detection: only an idle, valid, unstalled mem stage can raise an exception
    always_comb begin
        take = 1'b0;
        code = EXC_NONE;
        if (rst && state_q == ST_IDLE && mem_valid_i && !stall_i) begin
            code = pick_code(irq_pending(status_f, cause_f), mem_excepts_i);
            take = (code != EXC_NONE);
        end
    end

    // Comb outputs to CP0, forced to zero while reset is asserted
    always_comb begin
        except_type_o       = code;
        current_inst_addr_o = rst ? mem_inst_addr_i : '0;
        is_in_delayslot_o   = rst ? mem_in_delayslot_i : 1'b0;
    end

    // Next-state: load flush on take, count down the flush window, then release
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        new_pc_d = new_pc_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d  = ST_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = (code == EXC_ERET) ? epc_f : EXC_VECTOR;
                    cnt_d    = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d  = ST_IDLE;
                    flush_d  = 1'b0;
                    new_pc_d = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                flush_d  = 1'b0;
                new_pc_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    // FSM state and registered flush / redirect outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign flush_o  = flush_q;
    assign new_pc_o = new_pc_q;

`ifdef EXCEPT_STATS_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;

    // Taken-exception counter, wraps naturally at 2^32
    always_comb begin
        exc_cnt_d = take ? exc_cnt_q + 32'd1 : exc_cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign exc_count_o = exc_cnt_q;
`else
    assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// Testbench for except_ctrl: two instances (FLUSH_CYCLES=1 and 3) share
// stimulus; a rule-level reference model predicts codes, flush windows,
// redirect PCs and exception counts.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, stall, in_ds, wb_we;
    logic [4:0]  excepts, wb_addr;
    logic [31:0] inst_addr, status, cause, epc, wb_wdata;

    logic [31:0] et1, ia1, np1, ec1, et3, ia3, np3, ec3;
    logic        ds1, fl1, ds3, fl3;

    int tests = 0;
    int fails = 0;

    // reference model state
    int          left1 = 0, left3 = 0;
    logic [31:0] pc1 = '0, pc3 = '0;
    logic [31:0] cnt1 = '0, cnt3 = '0;
    int          prio_code [5] = '{8, 10, 13, 12, 14};

    always #5 clk = ~clk;

    except_ctrl u_dut1 (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .stall_i(stall),
        .mem_excepts_i(excepts), .mem_inst_addr_i(inst_addr), .mem_in_delayslot_i(in_ds),
        .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr), .wb_cp0_wdata_i(wb_wdata),
        .except_type_o(et1), .current_inst_addr_o(ia1), .is_in_delayslot_o(ds1),
        .flush_o(fl1), .new_pc_o(np1), .exc_count_o(ec1)
    );

    except_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .stall_i(stall),
        .mem_excepts_i(excepts), .mem_inst_addr_i(inst_addr), .mem_in_delayslot_i(in_ds),
        .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr), .wb_cp0_wdata_i(wb_wdata),
        .except_type_o(et3), .current_inst_addr_o(ia3), .is_in_delayslot_o(ds3),
        .flush_o(fl3), .new_pc_o(np3), .exc_count_o(ec3)
    );

    function automatic logic [31:0] fwd_status();
        return (wb_we && wb_addr == 5'd12) ? wb_wdata : status;
    endfunction

    function automatic logic [31:0] fwd_cause();
        if (wb_we && wb_addr == 5'd13) return (cause & ~32'h300) | (wb_wdata & 32'h300);
        return cause;
    endfunction

    function automatic logic [31:0] fwd_epc();
        return (wb_we && wb_addr == 5'd14) ? wb_wdata : epc;
    endfunction

    // expected code for an instance with 'left' flush cycles still to run
    function automatic logic [31:0] ref_code(input int left);
        logic [31:0] st, ca;
        if (!rst || left > 0 || !mem_valid || stall) return 32'h0;
        st = fwd_status();
        ca = fwd_cause();
        if ((((st >> 8) & (ca >> 8) & 32'hFF) != 0) && st[0] && !st[1]) return 32'h1;
        for (int i = 0; i < 5; i++) if (excepts[i]) return 32'(prio_code[i]);
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_count(input logic [31:0] c);
        exp_count = c;
`ifndef EXCEPT_STATS_EN
        exp_count = 32'h0;
`endif
    endfunction

    task automatic drive_idle();
        rst = 1'b1; mem_valid = 1'b0; stall = 1'b0; in_ds = 1'b0; excepts = '0;
        inst_addr = '0; status = '0; cause = '0; epc = '0;
        wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
    endtask

    // one clock; model advances with the inputs seen at the edge
    task automatic tick();
        logic [31:0] c1, c3, t1, t3;
        c1 = ref_code(left1);
        c3 = ref_code(left3);
        t1 = (c1 == 32'he) ? fwd_epc() : 32'h20;
        t3 = (c3 == 32'he) ? fwd_epc() : 32'h20;
        @(posedge clk);
        if (!rst) begin
            left1 = 0; left3 = 0; pc1 = '0; pc3 = '0; cnt1 = '0; cnt3 = '0;
        end else begin
            if (left1 > 0) left1--;
            else if (c1 != 0) begin left1 = 1; pc1 = t1; cnt1++; end
            if (left3 > 0) left3--;
            else if (c3 != 0) begin left3 = 3; pc3 = t3; cnt3++; end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        drive_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0; mem_valid = 1'b1; excepts = 5'b00001; inst_addr = 32'h100; in_ds = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (fl1 !== 1'b0 || fl3 !== 1'b0 || np1 !== 32'h0 || np3 !== 32'h0)
            begin fails++; $display("FAIL reset_regs: flush %b/%b pc %h/%h want 0", fl1, fl3, np1, np3); end
        tests++;
        if (et1 !== 32'h0 || et3 !== 32'h0 || ia1 !== 32'h0 || ds1 !== 1'b0)
            begin fails++; $display("FAIL reset_comb: type %h/%h addr %h ds %b want 0", et1, et3, ia1, ds1); end
        tests++;
        if (ec1 !== 32'h0 || ec3 !== 32'h0)
            begin fails++; $display("FAIL reset_count: %h/%h want 0", ec1, ec3); end
        drain();
    endtask

    task automatic test_syscall();
        drive_idle();
        mem_valid = 1'b1; excepts = 5'b00001; inst_addr = 32'h100;
        #1;
        tests++;
        if (et1 !== 32'h8 || et3 !== 32'h8)
            begin fails++; $display("FAIL sys_code: %h/%h want 8", et1, et3); end
        tests++;
        if (ia1 !== 32'h100 || ds1 !== 1'b0)
            begin fails++; $display("FAIL sys_pass: addr %h ds %b want 100/0", ia1, ds1); end
        tick(); #1;
        tests++;
        if (fl1 !== 1'b1 || fl3 !== 1'b1 || np1 !== 32'h20 || np3 !== 32'h20)
            begin fails++; $display("FAIL sys_flush: flush %b/%b pc %h/%h want 1/1 20/20", fl1, fl3, np1, np3); end
        tests++;
        if (et1 !== 32'h0 || et3 !== 32'h0)
            begin fails++; $display("FAIL sys_suppress: %h/%h want 0", et1, et3); end
        drain();
    endtask

    task automatic test_interrupt();
        drive_idle();
        mem_valid = 1'b1; status = 32'h0000_0401; cause = 32'h0000_0400;
        inst_addr = 32'h204; in_ds = 1'b1;
        #1;
        tests++;
        if (et1 !== 32'h1 || ds1 !== 1'b1 || ia1 !== 32'h204)
            begin fails++; $display("FAIL int_code: type %h ds %b addr %h want 1/1/204", et1, ds1, ia1); end
        drain();
    endtask

    task automatic test_eret_fwd();
        drive_idle();
        mem_valid = 1'b1; excepts = 5'b10000; epc = 32'h40;
        wb_we = 1'b1; wb_addr = 5'd14; wb_wdata = 32'h88;
        #1;
        tests++;
        if (et1 !== 32'he || et3 !== 32'he)
            begin fails++; $display("FAIL eret_code: %h/%h want e", et1, et3); end
        tick(); #1;
        tests++;
        if (fl1 !== 1'b1 || np1 !== 32'h88 || np3 !== 32'h88)
            begin fails++; $display("FAIL eret_pc: flush %b pc %h/%h want 1 88", fl1, np1, np3); end
        drain();
    endtask

    task automatic test_cause_fwd();
        drive_idle();
        mem_valid = 1'b1; status = 32'h0000_0101;
        wb_we = 1'b1; wb_addr = 5'd13; wb_wdata = 32'h0000_0100;
        #1;
        tests++;
        if (et1 !== 32'h1) begin fails++; $display("FAIL cause_sw_fwd: %h want 1", et1); end
        status = 32'h0000_0401; wb_wdata = 32'h0000_0400;
        #1;
        tests++;
        if (et1 !== 32'h0) begin fails++; $display("FAIL cause_hw_masked: %h want 0", et1); end
        status = 32'h0; cause = 32'h0000_0400; wb_addr = 5'd12; wb_wdata = 32'h0000_0401;
        #1;
        tests++;
        if (et1 !== 32'h1) begin fails++; $display("FAIL status_fwd: %h want 1", et1); end
        drain();
    endtask

    task automatic test_priority_flush3();
        drive_idle();
        mem_valid = 1'b1; excepts = 5'b01001; status = 32'h0000_0401; cause = 32'h0000_0400;
        #1;
        tests++;
        if (et3 !== 32'h1) begin fails++; $display("FAIL prio_code: %h want 1", et3); end
        excepts = 5'b01110; status = 32'h0;
        #1;
        tests++;
        if (et3 !== 32'ha) begin fails++; $display("FAIL prio_inv: %h want a", et3); end
        excepts = 5'b01001; status = 32'h0000_0401;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            tests++;
            if (fl3 !== 1'b1 || et3 !== 32'h0 || np3 !== 32'h20)
                begin fails++; $display("FAIL flush3_win%0d: flush %b type %h pc %h want 1/0/20", k, fl3, et3, np3); end
        end
        tick(); #1;
        tests++;
        if (fl3 !== 1'b0 || et3 !== 32'h1)
            begin fails++; $display("FAIL flush3_end: flush %b type %h want 0/1", fl3, et3); end
        drain();
    endtask

    task automatic test_exl_stall();
        logic [31:0] base3;
        drive_idle();
        base3 = cnt3;
        mem_valid = 1'b1; stall = 1'b1; excepts = 5'b00001;
        status = 32'h0000_0403; cause = 32'h0000_0400;
        #1;
        tests++;
        if (et1 !== 32'h0 || et3 !== 32'h0)
            begin fails++; $display("FAIL stall_block: %h/%h want 0", et1, et3); end
        tick(); #1;
        tests++;
        if (fl3 !== 1'b0 || ec3 !== exp_count(base3))
            begin fails++; $display("FAIL stall_noflush: flush %b cnt %h want 0/%h", fl3, ec3, exp_count(base3)); end
        stall = 1'b0;
        #1;
        tests++;
        if (et3 !== 32'h8) begin fails++; $display("FAIL exl_sys: %h want 8", et3); end
        tick(); #1;
        tests++;
        if (ec3 !== exp_count(base3 + 32'd1))
            begin fails++; $display("FAIL exl_count: %h want %h", ec3, exp_count(base3 + 32'd1)); end
        drain();
    endtask

    task automatic test_back_to_back();
        drive_idle();
        mem_valid = 1'b1; excepts = 5'b00100; inst_addr = 32'h500;
        #1;
        tests++;
        if (et1 !== 32'hd) begin fails++; $display("FAIL b2b_first: %h want d", et1); end
        tick(); #1;
        tests++;
        if (fl1 !== 1'b1 || et1 !== 32'h0)
            begin fails++; $display("FAIL b2b_flush: flush %b type %h want 1/0", fl1, et1); end
        tick(); #1;
        tests++;
        if (fl1 !== 1'b0 || et1 !== 32'hd)
            begin fails++; $display("FAIL b2b_second: flush %b type %h want 0/d", fl1, et1); end
        tick(); #1;
        tests++;
        if (fl1 !== 1'b1 || np1 !== 32'h20)
            begin fails++; $display("FAIL b2b_reflush: flush %b pc %h want 1/20", fl1, np1); end
        drain();
    endtask

    task automatic test_reset_mid_flush();
        drive_idle();
        mem_valid = 1'b1; excepts = 5'b00001; inst_addr = 32'h300;
        tick(); #1;
        tests++;
        if (fl3 !== 1'b1) begin fails++; $display("FAIL mid_pre: flush %b want 1", fl3); end
        #2; rst = 1'b0; #1;
        tests++;
        if (fl1 !== 1'b0 || fl3 !== 1'b0 || np1 !== 32'h0 || np3 !== 32'h0 || et3 !== 32'h0)
            begin fails++; $display("FAIL mid_reset: flush %b/%b pc %h/%h type %h want 0", fl1, fl3, np1, np3, et3); end
        left1 = 0; left3 = 0; pc1 = '0; pc3 = '0; cnt1 = '0; cnt3 = '0;
        @(negedge clk); rst = 1'b1; #1;
        tests++;
        if (et1 !== 32'h8 || et3 !== 32'h8)
            begin fails++; $display("FAIL mid_idle: %h/%h want 8", et1, et3); end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] e1, e3;
        for (int n = 0; n < 300; n++) begin
            rst = 1'b1;
            mem_valid = ($urandom_range(0, 4) != 0);
            stall = ($urandom_range(0, 4) == 0);
            excepts = ($urandom_range(0, 2) == 0) ? 5'h0 : 5'($urandom_range(1, 31));
            inst_addr = $urandom; in_ds = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: status = 32'h0000_0401;
                1: status = 32'h0000_0403;
                2: status = 32'h0000_FF01;
                default: status = $urandom;
            endcase
            cause = ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(8, 15)) : 32'h0;
            epc = $urandom;
            wb_we = ($urandom_range(0, 3) == 0);
            wb_addr = 5'($urandom_range(11, 15));
            wb_wdata = $urandom;
            #1;
            e1 = ref_code(left1);
            e3 = ref_code(left3);
            tests++;
            if (et1 !== e1 || et3 !== e3)
                begin fails++; $display("FAIL rnd_code[%0d]: %h/%h want %h/%h", n, et1, et3, e1, e3); end
            tests++;
            if (fl1 !== (left1 > 0) || fl3 !== (left3 > 0))
                begin fails++; $display("FAIL rnd_flush[%0d]: %b/%b want %b/%b", n, fl1, fl3, left1 > 0, left3 > 0); end
            if (left1 > 0) begin
                tests++;
                if (np1 !== pc1) begin fails++; $display("FAIL rnd_pc1[%0d]: %h want %h", n, np1, pc1); end
            end
            if (left3 > 0) begin
                tests++;
                if (np3 !== pc3) begin fails++; $display("FAIL rnd_pc3[%0d]: %h want %h", n, np3, pc3); end
            end
            tests++;
            if (ia3 !== inst_addr || ds3 !== in_ds)
                begin fails++; $display("FAIL rnd_pass[%0d]: %h/%b want %h/%b", n, ia3, ds3, inst_addr, in_ds); end
            tests++;
            if (ec1 !== exp_count(cnt1) || ec3 !== exp_count(cnt3))
                begin fails++; $display("FAIL rnd_count[%0d]: %h/%h want %h/%h", n, ec1, ec3, exp_count(cnt1), exp_count(cnt3)); end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_interrupt();
        test_eret_fwd();
        test_cause_fwd();
        test_priority_flush3();
        test_exl_stall();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
